// File: rtl/isp_csc_rgb2gray.sv
// isp_csc_rgb2gray: streaming RGB888 -> 8-bit luma converter (BT.601 weights).
// Three elastic pipeline stages: products, rounded sum, shifted/saturated byte.
// Each stage loads when it is empty or when its content moves on in the same cycle.
// Up to three pixels are held under backpressure.
module isp_csc_rgb2gray #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned COEF_R     = 77,
    parameter int unsigned COEF_G     = 150,
    parameter int unsigned COEF_B     = 29,
    parameter int unsigned COEF_FRAC  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,        // synchronous, active-high
    input  logic [DATA_WIDTH-1:0] data_m_rgb,
    input  logic                  valid_m,
    output logic                  ready_m,
    output logic                  valid_s,
    input  logic                  ready_s,
    output logic [7:0]            data_s_gray
);

    // Channel, coefficient and accumulator widths derived from the parameters.
    localparam int unsigned CH_W     = DATA_WIDTH / 3;
    localparam int unsigned OUT_W    = 8;
    localparam int unsigned COEF_MAX_RG = (COEF_R > COEF_G) ? COEF_R : COEF_G;
    localparam int unsigned COEF_MAX = (COEF_MAX_RG > COEF_B) ? COEF_MAX_RG : COEF_B;
    localparam int unsigned COEF_W   = (COEF_MAX > 1) ? $clog2(COEF_MAX + 1) : 1;
    localparam int unsigned PROD_W   = CH_W + COEF_W;
    // Three products need two carry bits; keep room for the rounding constant too.
    localparam int unsigned SUM_W    = ((COEF_FRAC > PROD_W) ? COEF_FRAC : PROD_W) + 2;
    localparam int unsigned RND      = (COEF_FRAC > 0) ? (1 << (COEF_FRAC - 1)) : 0;
    localparam int unsigned SAT      = (1 << OUT_W) - 1;

    // Input channel split: R in the top third, B in the bottom third.
    logic [CH_W-1:0] ch_r;
    logic [CH_W-1:0] ch_g;
    logic [CH_W-1:0] ch_b;

    assign ch_r = data_m_rgb[3*CH_W-1 -: CH_W];
    assign ch_g = data_m_rgb[2*CH_W-1 -: CH_W];
    assign ch_b = data_m_rgb[CH_W-1   -: CH_W];

    // Stage state.
    logic              v1_q, v1_d;
    logic              v2_q, v2_d;
    logic              v3_q, v3_d;
    logic [PROD_W-1:0] prod_r_q, prod_r_d;
    logic [PROD_W-1:0] prod_g_q, prod_g_d;
    logic [PROD_W-1:0] prod_b_q, prod_b_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [OUT_W-1:0]  gray_q, gray_d;

    // Per-stage load enables and handshake qualifiers.
    logic             ld1_c;
    logic             ld2_c;
    logic             ld3_c;
    logic             in_xfer_c;
    logic [SUM_W-1:0] shifted_c;

    // Elastic load chain: a stage loads when empty or when its content drains.
    always_comb begin
        ld3_c     = !v3_q || ready_s;
        ld2_c     = !v2_q || ld3_c;
        ld1_c     = !v1_q || ld2_c;
        ready_m   = ld1_c && !rst_n;
        in_xfer_c = valid_m && ready_m;
    end

    // Next-state for valids and datapath registers; defaults hold current contents.
    always_comb begin
        v1_d      = v1_q;
        v2_d      = v2_q;
        v3_d      = v3_q;
        prod_r_d  = prod_r_q;
        prod_g_d  = prod_g_q;
        prod_b_d  = prod_b_q;
        sum_d     = sum_q;
        gray_d    = gray_q;
        shifted_c = sum_q >> COEF_FRAC;

        if (ld1_c) begin
            v1_d = in_xfer_c;
            if (in_xfer_c) begin
                prod_r_d = PROD_W'(ch_r) * PROD_W'(COEF_R);
                prod_g_d = PROD_W'(ch_g) * PROD_W'(COEF_G);
                prod_b_d = PROD_W'(ch_b) * PROD_W'(COEF_B);
            end
        end

        if (ld2_c) begin
            v2_d = v1_q;
            if (v1_q) begin
                sum_d = SUM_W'(prod_r_q) + SUM_W'(prod_g_q)
                      + SUM_W'(prod_b_q) + SUM_W'(RND);
            end
        end

        if (ld3_c) begin
            v3_d = v2_q;
            if (v2_q) begin
                gray_d = (shifted_c > SUM_W'(SAT)) ? OUT_W'(SAT) : OUT_W'(shifted_c);
            end
        end
    end

    // State registers with synchronous active-high reset discarding in-flight pixels.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            prod_r_q <= '0;
            prod_g_q <= '0;
            prod_b_q <= '0;
            sum_q    <= '0;
            gray_q   <= '0;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            v3_q     <= v3_d;
            prod_r_q <= prod_r_d;
            prod_g_q <= prod_g_d;
            prod_b_q <= prod_b_d;
            sum_q    <= sum_d;
            gray_q   <= gray_d;
        end
    end

    assign valid_s     = v3_q;
    assign data_s_gray = gray_q;

endmodule

// File: tb/tb_isp_csc_rgb2gray.sv
// Directed bench for isp_csc_rgb2gray: latency, streaming, gaps, backpressure, reset.
module tb_isp_csc_rgb2gray;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] data_m_rgb;
    logic        valid_m;
    logic        ready_m;
    logic        valid_s;
    logic        ready_s;
    logic [7:0]  data_s_gray;

    int          n_vec;
    int          n_err;
    int          acc_cnt;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    isp_csc_rgb2gray dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_m_rgb  (data_m_rgb),
        .valid_m     (valid_m),
        .ready_m     (ready_m),
        .valid_s     (valid_s),
        .ready_s     (ready_s),
        .data_s_gray (data_s_gray)
    );

    // Reference luma: round-half-up BT.601 with saturation.
    function automatic logic [7:0] ref_gray(input logic [23:0] p);
        int s;
        s = int'(p[23:16]) * 77 + int'(p[15:8]) * 150 + int'(p[7:0]) * 29 + 128;
        s = s >> 8;
        return (s > 255) ? 8'hFF : 8'(s);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, score outputs, return 1ns after edge.
    task automatic cycle();
        logic       in_x;
        logic       out_x;
        logic [7:0] od;
        #1;
        in_x  = valid_m && ready_m && !rst_n;
        out_x = valid_s && ready_s && !rst_n;
        od    = data_s_gray;
        if (in_x) begin
            exp_q.push_back(ref_gray(data_m_rgb));
            acc_cnt++;
        end
        @(posedge clk);
        #1;
        if (out_x) begin
            chk("out_has_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("out_data", 32'(od), 32'(exp_q.pop_front()));
        end
    endtask

    // Single pixel with ready_s=1: valid_s rises exactly three clocks after presentation.
    task automatic single(input logic [23:0] pix, input logic [7:0] gy);
        data_m_rgb = pix;
        valid_m    = 1'b1;
        #1;
        chk("single_ready_m", 32'(ready_m), 32'd1);
        cycle();
        valid_m    = 1'b0;
        data_m_rgb = 24'hA5_5A_C3;
        chk("lat_edge1_valid_s", 32'(valid_s), 32'd0);
        cycle();
        chk("lat_edge2_valid_s", 32'(valid_s), 32'd0);
        cycle();
        chk("lat_edge3_valid_s", 32'(valid_s), 32'd1);
        chk("single_gray", 32'(data_s_gray), 32'(gy));
        cycle();
        chk("single_after_valid_s", 32'(valid_s), 32'd0);
    endtask

    task automatic drain();
        valid_m = 1'b0;
        ready_s = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] pix [6];
        logic [7:0]  gy  [6];
        logic [7:0]  held;
        bit          have;

        pix[0] = 24'hFFFFFF; gy[0] = 8'd255;
        pix[1] = 24'h000000; gy[1] = 8'd0;
        pix[2] = 24'hFF0000; gy[2] = 8'd77;
        pix[3] = 24'h00FF00; gy[3] = 8'd149;
        pix[4] = 24'h0000FF; gy[4] = 8'd29;
        pix[5] = 24'h808080; gy[5] = 8'd128;

        n_vec      = 0;
        n_err      = 0;
        acc_cnt    = 0;
        rst_n      = 1'b1;
        valid_m    = 1'b0;
        ready_s    = 1'b0;
        data_m_rgb = 24'h0;

        // Reset.
        #1;
        chk("reset_ready_m_comb", 32'(ready_m), 32'd0);
        cycle();
        cycle();
        chk("reset_valid_s", 32'(valid_s), 32'd0);
        chk("reset_data", 32'(data_s_gray), 32'd0);
        chk("reset_ready_m", 32'(ready_m), 32'd0);
        rst_n   = 1'b0;
        ready_s = 1'b1;
        #1;
        chk("post_reset_ready_m", 32'(ready_m), 32'd1);

        // Directed single pixels.
        for (int i = 0; i < 6; i++) single(pix[i], gy[i]);

        // Full-rate stream.
        for (int i = 0; i < 1000; i++) begin
            valid_m    = 1'b1;
            data_m_rgb = 24'($urandom);
            chk("stream_ready_m", 32'(ready_m), 32'd1);
            if (i >= 3) chk("stream_valid_s", 32'(valid_s), 32'd1);
            cycle();
        end
        drain();

        // Random input gaps.
        for (int i = 0; i < 300; i++) begin
            valid_m    = 1'($urandom_range(0, 1));
            data_m_rgb = 24'($urandom);
            cycle();
        end
        drain();

        // Backpressure: three pixels fit, then ready_m drops and output holds.
        ready_s = 1'b0;
        acc_cnt = 0;
        have    = 1'b0;
        held    = 8'h0;
        for (int i = 0; i < 10; i++) begin
            valid_m    = 1'b1;
            data_m_rgb = 24'($urandom);
            cycle();
            if (valid_s) begin
                if (!have) begin
                    held = data_s_gray;
                    have = 1'b1;
                end else begin
                    chk("stall_hold_data", 32'(data_s_gray), 32'(held));
                end
            end
        end
        chk("bp_accept_count", 32'(acc_cnt), 32'd3);
        chk("bp_ready_m", 32'(ready_m), 32'd0);
        chk("bp_valid_s", 32'(valid_s), 32'd1);
        drain();

        // Random valid_m and ready_s.
        for (int i = 0; i < 3000; i++) begin
            valid_m    = 1'($urandom_range(0, 1));
            ready_s    = 1'($urandom_range(0, 1));
            data_m_rgb = 24'($urandom);
            cycle();
        end
        drain();

        // Reset with three pixels in flight.
        ready_s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_m    = 1'b1;
            data_m_rgb = 24'($urandom);
            cycle();
        end
        chk("inflight_valid_s", 32'(valid_s), 32'd1);
        rst_n = 1'b1;
        #1;
        chk("midrst_ready_m_comb", 32'(ready_m), 32'd0);
        cycle();
        chk("midrst_valid_s", 32'(valid_s), 32'd0);
        chk("midrst_data", 32'(data_s_gray), 32'd0);
        exp_q.delete();
        rst_n   = 1'b0;
        valid_m = 1'b0;
        ready_s = 1'b1;
        cycle();
        chk("post_midrst_idle_valid_s", 32'(valid_s), 32'd0);
        single(24'h808080, 8'd128);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("no_stale_valid_s", 32'(valid_s), 32'd0);
        end
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
